// File: rtl/tug_scoreboard.sv
// Tug-of-war scoreboard: counts round wins, freezes the field between rounds, declares a champion.
// Latency: a win pulse sampled at a rising edge updates score/hex/fieldHold right after that edge.
// Backpressure: none; win pulses arriving while the field is held or the game is over are dropped.
//
// Ports:
//   Clock, Reset        - rising-edge clock, synchronous active-high reset
//   leftWin, rightWin   - one-cycle round-win pulses from the end field lights
//   roundReset          - one-cycle pulse clearing the field lights for the next round
//   fieldHold           - freezes field lights and player inputs while high
//   leftScore/rightScore- round-win counts (0..WIN_SCORE)
//   hexLeft/hexRight    - active-low 7-segment codes {g,f,e,d,c,b,a} of the scores
//   gameOver, champL/R  - game finished and which side won
module tug_scoreboard #(
  parameter int WIN_SCORE   = 7,
  parameter int HOLD_CYCLES = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       leftWin,
  input  logic       rightWin,
  output logic       roundReset,
  output logic       fieldHold,
  output logic [2:0] leftScore,
  output logic [2:0] rightScore,
  output logic [6:0] hexLeft,
  output logic [6:0] hexRight,
  output logic       gameOver,
  output logic       champL,
  output logic       champR
);

  typedef enum logic [1:0] {PLAY, HOLD, RRST, OVER} state_t;

  localparam logic [2:0] WIN_VAL   = 3'(WIN_SCORE);
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  state_t     r_state;
  logic [7:0] r_holdCnt;
  logic [2:0] r_leftScore;
  logic [2:0] r_rightScore;
  logic       r_champL;
  logic       r_champR;
  logic       r_roundReset;
  logic       r_fieldHold;
  logic       r_gameOver;

  logic       w_oneWin;
  logic [2:0] w_leftNext;
  logic [2:0] w_rightNext;
  logic [2:0] w_newScore;
  logic       w_gameWon;

  // Simultaneous pulses cancel out, so only a lone pulse counts as a round win.
  assign w_oneWin    = leftWin ^ rightWin;
  // Scores in PLAY are always below WIN_SCORE (<= 6), so +1 cannot wrap.
  assign w_leftNext  = r_leftScore + 3'd1;
  assign w_rightNext = r_rightScore + 3'd1;
  assign w_newScore  = leftWin ? w_leftNext : w_rightNext;
  assign w_gameWon   = (w_newScore == WIN_VAL);

  // The hold window is HOLD_CYCLES cycles of fieldHold in total, the last of
  // which is the RRST cycle. The counter is loaded with HOLD_CYCLES-1 and the
  // FSM moves to RRST as the counter reaches 0, so HOLD itself lasts
  // HOLD_CYCLES-1 cycles; with HOLD_CYCLES==1 the counter starts at 0 and the
  // win goes straight to RRST.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state      <= PLAY;
      r_holdCnt    <= 8'd0;
      r_leftScore  <= 3'd0;
      r_rightScore <= 3'd0;
      r_champL     <= 1'b0;
      r_champR     <= 1'b0;
      r_roundReset <= 1'b0;
      r_fieldHold  <= 1'b0;
      r_gameOver   <= 1'b0;
    end else begin
      case (r_state)
        PLAY: begin
          if (w_oneWin) begin
            if (leftWin) r_leftScore  <= w_leftNext;
            else         r_rightScore <= w_rightNext;
            r_fieldHold <= 1'b1;
            if (w_gameWon) begin
              r_state    <= OVER;
              r_gameOver <= 1'b1;
              r_champL   <= leftWin;
              r_champR   <= rightWin;
            end else if (HOLD_CYCLES == 1) begin
              r_state      <= RRST;
              r_holdCnt    <= 8'd0;
              r_roundReset <= 1'b1;
            end else begin
              r_state   <= HOLD;
              r_holdCnt <= HOLD_LOAD;
            end
          end
        end
        HOLD: begin
          r_holdCnt <= r_holdCnt - 8'd1;
          if (r_holdCnt <= 8'd1) begin
            r_state      <= RRST;
            r_roundReset <= 1'b1;
          end
        end
        RRST: begin
          r_state      <= PLAY;
          r_holdCnt    <= 8'd0;
          r_roundReset <= 1'b0;
          r_fieldHold  <= 1'b0;
        end
        OVER: begin
          r_state <= OVER;
        end
        default: begin
          r_state      <= PLAY;
          r_roundReset <= 1'b0;
          r_fieldHold  <= 1'b0;
        end
      endcase
    end
  end

  function automatic logic [6:0] seg7(input logic [2:0] value);
    logic [6:0] code;
    code = 7'b1000000;
    case (value)
      3'd0: code = 7'b1000000;
      3'd1: code = 7'b1111001;
      3'd2: code = 7'b0100100;
      3'd3: code = 7'b0110000;
      3'd4: code = 7'b0011001;
      3'd5: code = 7'b0010010;
      3'd6: code = 7'b0000010;
      3'd7: code = 7'b1111000;
      default: code = 7'b1000000;
    endcase
    return code;
  endfunction

  assign roundReset = r_roundReset;
  assign fieldHold  = r_fieldHold;
  assign gameOver   = r_gameOver;
  assign champL     = r_champL;
  assign champR     = r_champR;
  assign leftScore  = r_leftScore;
  assign rightScore = r_rightScore;
  assign hexLeft    = seg7(r_leftScore);
  assign hexRight   = seg7(r_rightScore);

endmodule

// File: tb/tb_tug_scoreboard.sv
// Bench for tug_scoreboard: directed game scenarios plus random play, checked every cycle.
// Latency: outputs compared 1 time unit after each rising edge against the reference model.
// Backpressure: none; the model drops wins while the field is held or the game is over.
module tb_tug_scoreboard;
  localparam int WIN_SCORE   = 7;
  localparam int HOLD_CYCLES = 4;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       leftWin = 1'b0;
  logic       rightWin = 1'b0;
  logic       roundReset;
  logic       fieldHold;
  logic [2:0] leftScore;
  logic [2:0] rightScore;
  logic [6:0] hexLeft;
  logic [6:0] hexRight;
  logic       gameOver;
  logic       champL;
  logic       champR;

  tug_scoreboard #(.WIN_SCORE(WIN_SCORE), .HOLD_CYCLES(HOLD_CYCLES)) dut (
    .Clock(Clock), .Reset(Reset), .leftWin(leftWin), .rightWin(rightWin),
    .roundReset(roundReset), .fieldHold(fieldHold),
    .leftScore(leftScore), .rightScore(rightScore),
    .hexLeft(hexLeft), .hexRight(hexRight),
    .gameOver(gameOver), .champL(champL), .champR(champR)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: scores, cycles of field hold still to come, game state.
  int m_left, m_right, m_busy;
  bit m_over, m_champL, m_champR;
  logic [6:0] seg_ref [0:7];

  int fh_cnt, rr_cnt;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, act, exp);
  endtask

  // A lone win in open play scores a point, then the field is held for
  // HOLD_CYCLES cycles, the last one carrying the round-reset pulse.
  task automatic model_step(input bit l, input bit r, input bit rst);
    if (rst) begin
      m_left = 0; m_right = 0; m_busy = 0;
      m_over = 0; m_champL = 0; m_champR = 0;
    end else if (m_over) begin
      // game finished, nothing changes until reset
    end else if (m_busy > 0) begin
      m_busy--;
    end else if (l != r) begin
      if (l) m_left++; else m_right++;
      if (m_left == WIN_SCORE) begin
        m_over = 1; m_champL = 1;
      end else if (m_right == WIN_SCORE) begin
        m_over = 1; m_champR = 1;
      end else begin
        m_busy = HOLD_CYCLES;
      end
    end
  endtask

  task automatic check_outputs();
    chk("leftScore",  32'(leftScore),  32'(m_left));
    chk("rightScore", 32'(rightScore), 32'(m_right));
    chk("hexLeft",    32'(hexLeft),    32'(seg_ref[m_left]));
    chk("hexRight",   32'(hexRight),   32'(seg_ref[m_right]));
    chk("fieldHold",  32'(fieldHold),  32'(m_over || m_busy > 0));
    chk("roundReset", 32'(roundReset), 32'(!m_over && m_busy == 1));
    chk("gameOver",   32'(gameOver),   32'(m_over));
    chk("champL",     32'(champL),     32'(m_champL));
    chk("champR",     32'(champR),     32'(m_champR));
  endtask

  task automatic cycle(input bit l, input bit r, input bit rst);
    @(negedge Clock);
    leftWin  = l;
    rightWin = r;
    Reset    = rst;
    @(posedge Clock);
    model_step(l, r, rst);
    #1;
    check_outputs();
    fh_cnt += int'(fieldHold === 1'b1);
    rr_cnt += int'(roundReset === 1'b1);
  endtask

  task automatic do_reset();
    cycle(0, 0, 1);
    cycle(0, 0, 1);
    cycle(0, 0, 0);
  endtask

  initial begin
    seg_ref[0] = 7'b1000000; seg_ref[1] = 7'b1111001;
    seg_ref[2] = 7'b0100100; seg_ref[3] = 7'b0110000;
    seg_ref[4] = 7'b0011001; seg_ref[5] = 7'b0010010;
    seg_ref[6] = 7'b0000010; seg_ref[7] = 7'b1111000;
    m_left = 0; m_right = 0; m_busy = 0;
    m_over = 0; m_champL = 0; m_champR = 0;
    fh_cnt = 0; rr_cnt = 0;

    // Reset values, also while Reset is still held.
    cycle(0, 0, 1);
    chk("rst_hexL", 32'(hexLeft), 32'(7'b1000000));
    cycle(0, 0, 1);
    cycle(0, 0, 0);
    chk("rst_fieldHold", 32'(fieldHold), 32'd0);

    // Single left win: one point, 4 held cycles, one round reset.
    fh_cnt = 0; rr_cnt = 0;
    cycle(1, 0, 0);
    chk("win1_leftScore", 32'(leftScore), 32'd1);
    chk("win1_hexL", 32'(hexLeft), 32'(7'b1111001));
    for (int i = 0; i < 5; i++) cycle(0, 0, 0);
    chk("win1_hold_len", 32'(fh_cnt), 32'(HOLD_CYCLES));
    chk("win1_rr_pulses", 32'(rr_cnt), 32'd1);

    // Both pulses together: ignored.
    fh_cnt = 0; rr_cnt = 0;
    cycle(1, 1, 0);
    cycle(0, 0, 0);
    chk("tie_leftScore", 32'(leftScore), 32'd1);
    chk("tie_rightScore", 32'(rightScore), 32'd0);
    chk("tie_no_hold", 32'(fh_cnt), 32'd0);
    chk("tie_no_rr", 32'(rr_cnt), 32'd0);

    // Right pulses repeated through the hold window score once.
    for (int i = 0; i < HOLD_CYCLES + 1; i++) cycle(0, 1, 0);
    chk("hold_ignore_right", 32'(rightScore), 32'd1);
    cycle(0, 0, 0);

    // Seven right rounds end the game with no trailing round reset.
    do_reset();
    for (int k = 0; k < WIN_SCORE; k++) begin
      rr_cnt = 0;
      cycle(0, 1, 0);
      for (int i = 0; i < HOLD_CYCLES; i++) cycle(0, 0, 0);
    end
    rr_cnt = 0;
    for (int i = 0; i < 8; i++) cycle(0, 0, 0);
    chk("over_rightScore", 32'(rightScore), 32'd7);
    chk("over_hexR", 32'(hexRight), 32'(7'b1111000));
    chk("over_gameOver", 32'(gameOver), 32'd1);
    chk("over_champR", 32'(champR), 32'd1);
    chk("over_champL", 32'(champL), 32'd0);
    chk("over_no_rr", 32'(rr_cnt), 32'd0);

    // Left pulses after game over change nothing; reset clears everything.
    for (int i = 0; i < 3; i++) cycle(1, 0, 0);
    chk("over_leftScore", 32'(leftScore), 32'd0);
    cycle(0, 0, 1);
    cycle(0, 0, 0);
    chk("post_over_gameOver", 32'(gameOver), 32'd0);
    chk("post_over_hexR", 32'(hexRight), 32'(7'b1000000));

    // Reset on the second hold cycle aborts the round without a round reset.
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    rr_cnt = 0;
    cycle(0, 0, 1);
    chk("abort_leftScore", 32'(leftScore), 32'd0);
    chk("abort_fieldHold", 32'(fieldHold), 32'd0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0);
    chk("abort_no_rr", 32'(rr_cnt), 32'd0);

    // Random play with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 79) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
